// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory responder: FSM encoding,
// data width, the NOP word and the address legality check.
package imem_pkg;

  localparam int DATA_W = 32;
  localparam logic [DATA_W-1:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Misaligned addresses and addresses past the last word are both illegal.
  function automatic logic addr_bad(input logic [31:0] addr, input int depth_words);
    return (addr[1:0] != 2'b00) || (addr >= (32'(depth_words) * 32'd4));
  endfunction

endpackage

// File: rtl/imem_responder_if.sv
// Fetch/loader bus between an instruction-fetch unit and the responder.
interface imem_responder_if;
  import imem_pkg::*;

  logic              req_valid;
  logic [31:0]       req_addr;
  logic              req_ready;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_data;
  logic              resp_err;
  logic              resp_ready;
  logic              wr_en;
  logic [31:0]       wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (
    output req_valid, req_addr, resp_ready, wr_en, wr_addr, wr_data,
    input  req_ready, resp_valid, resp_data, resp_err
  );

  modport slave (
    input  req_valid, req_addr, resp_ready, wr_en, wr_addr, wr_data,
    output req_ready, resp_valid, resp_data, resp_err
  );

endinterface

// File: rtl/imem_array.sv
// Word-addressed instruction storage: one write port, one registered read port.
// Contents are deliberately not reset; a same-edge read and write returns the old word.
module imem_array
  import imem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];
  logic [DATA_W-1:0] rdata_reg;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata_reg <= mem[raddr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/imem_responder.sv
// Single-outstanding instruction fetch responder with fixed latency and
// error reporting for misaligned or out-of-range fetches.
module imem_responder
  import imem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2
) (
  input logic              clk,
  input logic              reset,
  imem_responder_if.slave  bus
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t            state_reg, state_next;
  logic [3:0]        cnt_reg;
  logic [AW-1:0]     idx_reg;
  logic              err_reg;
  logic              rd_issued_reg;
  logic [DATA_W-1:0] resp_data_reg;
  logic              resp_err_reg;

  logic              req_hs;
  logic              rd_en;
  logic              rd_done;
  logic              wr_ok;
  logic [DATA_W-1:0] rd_data;

  assign req_hs  = bus.req_valid && (state_reg == ST_IDLE);
  // After the countdown one extra WAIT cycle issues the registered array read.
  assign rd_en   = (state_reg == ST_WAIT) && (cnt_reg == 4'd0) && !rd_issued_reg && !err_reg;
  assign rd_done = (state_reg == ST_WAIT) && rd_issued_reg;
  assign wr_ok   = reset && bus.wr_en && !addr_bad(bus.wr_addr, DEPTH_WORDS);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (req_hs)          state_next = ST_WAIT;
      ST_WAIT: if (rd_done)         state_next = ST_RESP;
      ST_RESP: if (bus.resp_ready)  state_next = ST_IDLE;
      default:                      state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_reg       <= 4'd0;
      idx_reg       <= '0;
      err_reg       <= 1'b0;
      rd_issued_reg <= 1'b0;
      resp_data_reg <= NOP_WORD;
      resp_err_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (req_hs) begin
            cnt_reg       <= CNT_LOAD;
            idx_reg       <= bus.req_addr[AW+1:2];
            err_reg       <= addr_bad(bus.req_addr, DEPTH_WORDS);
            rd_issued_reg <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (cnt_reg != 4'd0) begin
            cnt_reg <= cnt_reg - 4'd1;
          end else if (!rd_issued_reg) begin
            rd_issued_reg <= 1'b1;
          end else begin
            resp_data_reg <= err_reg ? NOP_WORD : rd_data;
            resp_err_reg  <= err_reg;
          end
        end
        default: ;
      endcase
    end
  end

  imem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (bus.wr_addr[AW+1:2]),
    .wdata (bus.wr_data),
    .re    (rd_en),
    .raddr (idx_reg),
    .rdata (rd_data)
  );

  assign bus.req_ready  = (state_reg == ST_IDLE);
  assign bus.resp_valid = (state_reg == ST_RESP);
  assign bus.resp_data  = resp_data_reg;
  assign bus.resp_err   = resp_err_reg;

  a_resp_stable: assert property (@(posedge clk) disable iff (!reset)
    (bus.resp_valid && !bus.resp_ready) |=>
      (bus.resp_valid && $stable(bus.resp_data) && $stable(bus.resp_err)));

endmodule

// File: tb/tb_imem_responder.sv
// Directed, table-driven bench for imem_responder (DEPTH_WORDS=64, LATENCY=2).
module tb_imem_responder;
  import imem_pkg::*;

  localparam int DEPTH = 64;
  localparam int LAT   = 2;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   tests = 0;
  int   fails = 0;
  vec_t vecs[9];

  always #5 clk = ~clk;

  imem_responder_if bus();

  imem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    bus.wr_en = 1'b1;
    bus.wr_addr = addr;
    bus.wr_data = data;
    tick();
    bus.wr_en = 1'b0;
    $display("[TB] write addr=%h data=%h", addr, data);
  endtask

  // Handshake, then count edges until resp_valid (bounded).
  task automatic do_req(input logic [31:0] addr, output logic [31:0] data,
                        output logic err, output int lat);
    bus.req_valid = 1'b1;
    bus.req_addr = addr;
    tick();
    bus.req_valid = 1'b0;
    bus.req_addr = 32'hFFFF_FFFF;
    lat = 0;
    while (lat < 40) begin
      tick();
      lat++;
      if (bus.resp_valid === 1'b1) break;
    end
    data = bus.resp_data;
    err = bus.resp_err;
    $display("[TB] fetch addr=%h data=%h err=%0d edges=%0d", addr, data, err, lat);
  endtask

  initial begin
    logic [31:0] d;
    logic        e;
    int          n;

    vecs[0] = '{32'h0000_000C, 32'h2008_0005, 1'b0};
    vecs[1] = '{32'h0000_0006, 32'h0000_0000, 1'b1};
    vecs[2] = '{32'h0000_0000, 32'h1111_0000, 1'b0};
    vecs[3] = '{32'h0000_0100, 32'h0000_0000, 1'b1};
    vecs[4] = '{32'h0000_0010, 32'h4444_0004, 1'b0};
    vecs[5] = '{32'h0000_00FC, 32'h6363_6363, 1'b0};
    vecs[6] = '{32'h0000_0101, 32'h0000_0000, 1'b1};
    vecs[7] = '{32'h8000_000C, 32'h0000_0000, 1'b1};
    vecs[8] = '{32'h0000_0003, 32'h0000_0000, 1'b1};

    bus.req_valid = 1'b0;
    bus.req_addr = 32'h0;
    bus.resp_ready = 1'b1;
    bus.wr_en = 1'b0;
    bus.wr_addr = 32'h0;
    bus.wr_data = 32'h0;

    repeat (3) tick();
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_data", bus.resp_data, 32'h0);
    check("rst_resp_err", 32'(bus.resp_err), 32'd0);
    reset = 1'b1;
    tick();
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);

    wr(32'h0000_0000, 32'h1111_0000);
    wr(32'h0000_000C, 32'h2008_0005);
    wr(32'h0000_0010, 32'h4444_0004);
    wr(32'h0000_0014, 32'h5555_0005);
    wr(32'h0000_00FC, 32'h6363_6363);
    // Illegal writes that would alias words 4, 0 and 3 if not dropped.
    wr(32'h0000_0011, 32'hDEAD_0011);
    wr(32'h0000_0100, 32'hDEAD_0100);
    wr(32'h8000_000C, 32'hDEAD_000C);

    for (int i = 0; i < 9; i++) begin
      check($sformatf("v%0d_req_ready", i), 32'(bus.req_ready), 32'd1);
      do_req(vecs[i].addr, d, e, n);
      check($sformatf("v%0d_latency", i), 32'(n), 32'(LAT + 1));
      check($sformatf("v%0d_data", i), d, vecs[i].data);
      check($sformatf("v%0d_err", i), 32'(e), 32'(vecs[i].err));
      tick();
      check($sformatf("v%0d_idle_after", i), {30'd0, bus.resp_valid, bus.req_ready}, 32'd1);
    end

    // Backpressure: response held for 5 cycles, stray request ignored.
    bus.resp_ready = 1'b0;
    do_req(32'h0000_000C, d, e, n);
    check("bp_latency", 32'(n), 32'(LAT + 1));
    for (int i = 0; i < 5; i++) begin
      bus.req_valid = 1'b1;
      bus.req_addr = 32'h0000_0010;
      check($sformatf("bp_hold%0d", i), {bus.resp_valid, bus.req_ready, bus.resp_err, 29'd0},
            {1'b1, 1'b0, 1'b0, 29'd0});
      check($sformatf("bp_data%0d", i), bus.resp_data, 32'h2008_0005);
      tick();
    end
    bus.req_valid = 1'b0;
    bus.resp_ready = 1'b1;
    tick();
    check("bp_release", {30'd0, bus.resp_valid, bus.req_ready}, 32'd1);
    check("bp_data_hold", bus.resp_data, 32'h2008_0005);
    repeat (4) tick();
    check("bp_no_queued_req", 32'(bus.resp_valid), 32'd0);
    $display("[TB] backpressure sequence done");

    // Reset during WAIT aborts; a write during reset must be dropped.
    bus.req_valid = 1'b1;
    bus.req_addr = 32'h0000_000C;
    tick();
    bus.req_valid = 1'b0;
    tick();
    reset = 1'b0;
    bus.wr_en = 1'b1;
    bus.wr_addr = 32'h0000_0014;
    bus.wr_data = 32'hBAD0_0005;
    tick();
    reset = 1'b1;
    bus.wr_en = 1'b0;
    check("abort_req_ready", 32'(bus.req_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("abort_no_resp%0d", i), 32'(bus.resp_valid), 32'd0);
      tick();
    end
    $display("[TB] reset-abort sequence done");
    do_req(32'h0000_000C, d, e, n);
    check("abort_next_latency", 32'(n), 32'(LAT + 1));
    check("abort_next_data", d, 32'h2008_0005);
    tick();
    do_req(32'h0000_0014, d, e, n);
    check("rst_write_ignored", d, 32'h5555_0005);
    tick();

    // Write to word 3 on the edge that reads it: old word first, new word after.
    bus.req_valid = 1'b1;
    bus.req_addr = 32'h0000_000C;
    tick();
    bus.req_valid = 1'b0;
    tick();
    bus.wr_en = 1'b1;
    bus.wr_addr = 32'h0000_000C;
    bus.wr_data = 32'hAAAA_AAAA;
    tick();
    bus.wr_en = 1'b0;
    tick();
    check("coll_resp_valid", 32'(bus.resp_valid), 32'd1);
    check("coll_old_data", bus.resp_data, 32'h2008_0005);
    $display("[TB] collision fetch data=%h", bus.resp_data);
    tick();
    do_req(32'h0000_000C, d, e, n);
    check("coll_new_data", d, 32'hAAAA_AAAA);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
